// File: rtl/dcache_ctrl_dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl_dm_pkg
//  Description : Shared definitions for the direct-mapped data-cache
//                controller: default geometry, FSM state encodings,
//                statistics counter width and a depth helper.
//                Optional statistics are enabled with DCACHE_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_ctrl_dm_pkg;

    // Default cache geometry: 2**5 lines of 3-bit tags.
    localparam int c_def_index_w = 5;
    localparam int c_def_tag_w   = 3;

    // Width of the optional read hit/miss statistics counters.
    localparam int c_stat_w = 16;

    // Controller state encodings.
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_rd_miss = 2'd1;
    localparam logic [1:0] c_st_wr_thru = 2'd2;
    localparam logic [1:0] c_st_flush   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = c_st_idle,
        RD_MISS = c_st_rd_miss,
        WR_THRU = c_st_wr_thru,
        FLUSH   = c_st_flush
    } state_e;

    // Number of cache lines for a given index width. The flush counter is
    // INDEX_W bits wide, so it covers exactly this many lines and wraps.
    function automatic int depth_of(input int index_w);
        return 1 << index_w;
    endfunction

endpackage : dcache_ctrl_dm_pkg
`default_nettype wire

// File: rtl/dcache_tag_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_tag_array
//  Description : Valid + tag storage for a direct-mapped cache. One
//                asynchronous read port, one install port (sets valid and
//                writes the tag), one single-line invalidate port and a
//                synchronous clear of every valid bit on rst.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_tag_array
    import dcache_ctrl_dm_pkg::*;
#(
    parameter int INDEX_W = c_def_index_w,
    parameter int TAG_W   = c_def_tag_w
) (
    input  logic               clk,
    input  logic               rst,
    // asynchronous lookup
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    // line install
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    // single-line invalidate
    input  logic               inv_en,
    input  logic [INDEX_W-1:0] inv_idx
);

    localparam int c_depth = depth_of(INDEX_W);

    logic [c_depth-1:0] valid_q;
    logic [c_depth-1:0] valid_d;
    logic [TAG_W-1:0]   tags_q [c_depth];
    logic [TAG_W-1:0]   tags_d [c_depth];

    // Next-state of the arrays: install and invalidate never target the same
    // cycle in practice; invalidate is applied last so it would win.
    always_comb begin
        valid_d = valid_q;
        tags_d  = tags_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tags_d[wr_idx]  = wr_tag;
        end
        if (inv_en) begin
            valid_d[inv_idx] = 1'b0;
        end
    end

    // Valid bits clear in a single reset cycle; tag contents need no reset
    // because they are only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        tags_q <= tags_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tags_q[rd_idx];

endmodule : dcache_tag_array
`default_nettype wire

// File: rtl/dcache_ctrl_dm.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl_dm
//  Description : Direct-mapped, write-through, write-no-allocate data-cache
//                controller. Detects hits, stalls the pipeline on read
//                misses and writes, sequences the memory-side handshake and
//                performs a line-by-line flush. Data RAM is external and is
//                written through the fill/update pulses.
//                Define DCACHE_STATS_EN to add saturating read hit/miss
//                counters (rd_hit_cnt / rd_miss_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl_dm
    import dcache_ctrl_dm_pkg::*;
#(
    parameter int INDEX_W = c_def_index_w,
    parameter int TAG_W   = c_def_tag_w
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               flush,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    input  logic               MsReady,
    output logic               stall,
    output logic               hit,
    output logic               fill,
    output logic               update,
    output logic               MsRead,
    output logic               MsWrite
`ifdef DCACHE_STATS_EN
    ,
    output logic [c_stat_w-1:0] rd_hit_cnt,
    output logic [c_stat_w-1:0] rd_miss_cnt
`endif
);

    localparam logic [INDEX_W-1:0] c_cnt_last = {INDEX_W{1'b1}};

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] idx_q,   idx_d;
    logic [TAG_W-1:0]   tag_q,   tag_d;
    logic               hit_q,   hit_d;
    logic [INDEX_W-1:0] cnt_q,   cnt_d;

    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic               w_hit;
    logic               w_wr_en;
    logic               w_inv_en;

    dcache_tag_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (index),
        .rd_valid (w_rd_valid),
        .rd_tag   (w_rd_tag),
        .wr_en    (w_wr_en),
        .wr_idx   (idx_q),
        .wr_tag   (tag_q),
        .inv_en   (w_inv_en),
        .inv_idx  (cnt_q)
    );

    // Raw lookup used for decisions; the port copy is forced low in reset.
    assign w_hit = w_rd_valid && (w_rd_tag == tag);
    assign hit   = w_hit && !rst;

    // Next-state and output decode; every output defaults to 0 and reset
    // overrides everything so an abandoned miss/write/flush leaves no trace.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tag_d    = tag_q;
        hit_d    = hit_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        fill     = 1'b0;
        update   = 1'b0;
        MsRead   = 1'b0;
        MsWrite  = 1'b0;
        w_wr_en  = 1'b0;
        w_inv_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    stall   = 1'b1;
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else if (MemRead) begin
                    // A simultaneous MemWrite is ignored: the access is a load.
                    if (!w_hit) begin
                        stall   = 1'b1;
                        idx_d   = index;
                        tag_d   = tag;
                        state_d = RD_MISS;
                    end
                end else if (MemWrite) begin
                    stall   = 1'b1;
                    idx_d   = index;
                    tag_d   = tag;
                    hit_d   = w_hit;
                    state_d = WR_THRU;
                end
            end

            RD_MISS: begin
                MsRead = 1'b1;
                stall  = 1'b1;
                if (MsReady) begin
                    fill    = 1'b1;
                    w_wr_en = 1'b1;
                    state_d = IDLE;
                end
            end

            WR_THRU: begin
                // Write-no-allocate: only a line that hit at capture time
                // gets its data RAM refreshed; tags/valid never change here.
                MsWrite = 1'b1;
                stall   = !MsReady;
                if (MsReady) begin
                    update  = hit_q;
                    state_d = IDLE;
                end
            end

            FLUSH: begin
                stall    = 1'b1;
                w_inv_en = 1'b1;
                cnt_d    = cnt_q + INDEX_W'(1);
                if (cnt_q == c_cnt_last) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            stall    = 1'b0;
            fill     = 1'b0;
            update   = 1'b0;
            MsRead   = 1'b0;
            MsWrite  = 1'b0;
            w_wr_en  = 1'b0;
            w_inv_en = 1'b0;
        end
    end

    // Controller state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tag_q   <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [c_stat_w-1:0] hit_cnt_q,  hit_cnt_d;
    logic [c_stat_w-1:0] miss_cnt_q, miss_cnt_d;
    logic                w_rd_hit_ev;
    logic                w_rd_miss_ev;

    // Only loads actually serviced from IDLE count; a pending flush takes
    // priority and the load is re-presented afterwards.
    assign w_rd_hit_ev  = (state_q == IDLE) && !flush && MemRead &&  w_hit;
    assign w_rd_miss_ev = (state_q == IDLE) && !flush && MemRead && !w_hit;

    // Saturating increment of the hit/miss counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (w_rd_hit_ev && (hit_cnt_q != {c_stat_w{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + c_stat_w'(1);
        end
        if (w_rd_miss_ev && (miss_cnt_q != {c_stat_w{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + c_stat_w'(1);
        end
    end

    // Statistics registers; cleared only by reset, never by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign rd_hit_cnt  = hit_cnt_q;
    assign rd_miss_cnt = miss_cnt_q;
`endif

endmodule : dcache_ctrl_dm
`default_nettype wire

// File: tb/tb_dcache_ctrl_dm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl_dm
//  Description : Self-checking bench for dcache_ctrl_dm. A driver issues
//                directed then random load/store/flush transactions, a
//                line-level cache model predicts each transaction's visible
//                behaviour into a queue, and a monitor reconstructs what the
//                DUT did and compares it against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl_dm;

    localparam int INDEX_W = 5;
    localparam int TAG_W   = 3;
    localparam int DEPTH   = 1 << INDEX_W;
    localparam int K_RD    = 0;
    localparam int K_WR    = 1;
    localparam int K_FL    = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               MemRead, MemWrite, flush, MsReady;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               stall, hit, fill, update, MsRead, MsWrite;
`ifdef DCACHE_STATS_EN
    logic [15:0]        rd_hit_cnt, rd_miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_ctrl_dm #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .flush    (flush),
        .index    (index),
        .tag      (tag),
        .MsReady  (MsReady),
        .stall    (stall),
        .hit      (hit),
        .fill     (fill),
        .update   (update),
        .MsRead   (MsRead),
        .MsWrite  (MsWrite)
`ifdef DCACHE_STATS_EN
        ,
        .rd_hit_cnt  (rd_hit_cnt),
        .rd_miss_cnt (rd_miss_cnt)
`endif
    );

    // Observable summary of one transaction.
    typedef struct packed {
        int kind;        // 0 load, 1 store, 2 flush
        int first_hit;   // hit in the request cycle
        int end_hit;     // hit in the completing cycle (loads only)
        int stall_after; // stall cycles after the request cycle
        int ms_cycles;   // cycles with MsRead or MsWrite high
        int fills;
        int updates;
        int both;        // MsRead and MsWrite ever high together
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    // Behavioural cache contents and statistics.
    bit         m_valid [DEPTH];
    logic [2:0] m_tag   [DEPTH];
    int         m_hits   = 0;
    int         m_misses = 0;

    function automatic string rec_str(input rec_t r);
        return $sformatf("kind=%0d fh=%0d eh=%0d stall=%0d ms=%0d fill=%0d upd=%0d both=%0d",
                         r.kind, r.first_hit, r.end_hit, r.stall_after,
                         r.ms_cycles, r.fills, r.updates, r.both);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic finish_now();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Predict a transaction from cache rules, push it, then drive it.
    // d = memory cycle (1-based) in which MsReady is returned.
    task automatic do_txn(input int kind, input int idx, input int tg, input int d);
        rec_t e;
        bit   h;
        int   k;
        int   guard;
        bit   done;
        h = m_valid[idx] && (m_tag[idx] == 3'(tg));
        e = '0;
        e.kind      = kind;
        e.first_hit = int'(h);
        if (kind == K_RD) begin
            e.end_hit = 1;
            m_hits++;                 // the (retried) load always hits in IDLE
            if (!h) begin
                e.stall_after = d;
                e.ms_cycles   = d;
                e.fills       = 1;
                m_valid[idx]  = 1'b1;
                m_tag[idx]    = 3'(tg);
                m_misses++;
            end
        end else if (kind == K_WR) begin
            e.stall_after = d - 1;
            e.ms_cycles   = d;
            e.updates     = int'(h);
        end else begin
            e.stall_after = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end
        exp_q.push_back(e);

        @(posedge clk); #1;
        index    = INDEX_W'(idx);
        tag      = TAG_W'(tg);
        MemRead  = (kind == K_RD);
        MemWrite = (kind == K_WR);
        flush    = (kind == K_FL);
        MsReady  = 1'b0;
        k        = 0;
        guard    = 0;
        forever begin
            @(negedge clk);
            done = !stall;
            @(posedge clk); #1;
            if (done) begin
                MemRead  = 1'b0;
                MemWrite = 1'b0;
                flush    = 1'b0;
                MsReady  = 1'b0;
                break;
            end
            flush   = 1'b0;
            MsReady = 1'b0;
            if (MsRead || MsWrite) begin
                k++;
                if (k == d) MsReady = 1'b1;
            end
            guard++;
            if (guard > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL txn_timeout: stall still %0d after %0d cycles, required 0", stall, guard);
                finish_now();
            end
        end
    endtask

    // Monitor: rebuilds each transaction from DUT outputs and scores it.
    rec_t cur;
    bit   act = 1'b0;
    bit   started;
    rec_t e_head;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            started = 1'b0;
            if (!act && (MemRead || MemWrite || flush)) begin
                act           = 1'b1;
                started       = 1'b1;
                cur           = '0;
                cur.kind      = flush ? K_FL : (MemRead ? K_RD : K_WR);
                cur.first_hit = int'(hit);
            end
            if (act) begin
                if (!started && stall) cur.stall_after++;
                if (MsRead || MsWrite) cur.ms_cycles++;
                if (fill)   cur.fills++;
                if (update) cur.updates++;
                if (MsRead && MsWrite) cur.both = 1;
                if (!stall) begin
                    act = 1'b0;
                    cur.end_hit = (cur.kind == K_RD) ? int'(hit) : 0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected: got %s, required no transaction", rec_str(cur));
                    end else begin
                        e_head = exp_q.pop_front();
                        if (cur != e_head) begin
                            n_err++;
                            $display("FAIL txn: got %s | required %s", rec_str(cur), rec_str(e_head));
                        end
                    end
                end
            end
        end
    end

    int r, idx, tg, d, gap, rst_tag;

    initial begin
        rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; flush = 1'b0;
        MsReady = 1'b1; index = 5'd3; tag = 3'd5;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({stall, hit, fill, update, MsRead, MsWrite}), 0);
`ifdef DCACHE_STATS_EN
        check("reset_hit_cnt",  int'(rd_hit_cnt),  0);
        check("reset_miss_cnt", int'(rd_miss_cnt), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0; MemRead = 1'b0; MsReady = 1'b0;
        @(negedge clk);
        check("idle_outputs", int'({stall, fill, update, MsRead, MsWrite}), 0);
        mon_en = 1'b1;

        // Directed scenarios
        do_txn(K_RD, 3, 5, 4);   // cold miss, 4 memory cycles
        do_txn(K_RD, 3, 5, 1);   // now hits
        do_txn(K_WR, 3, 5, 3);   // write hit -> update
        do_txn(K_WR, 7, 2, 2);   // write miss -> no update, no allocate
        do_txn(K_RD, 7, 2, 1);   // still a miss
        do_txn(K_RD, 3, 6, 2);   // conflicting tag replaces line
        do_txn(K_RD, 3, 5, 1);   // old tag now misses
        do_txn(K_RD, 0, 1, 1);
        do_txn(K_RD, 31, 4, 1);
        do_txn(K_FL, 0, 1, 1);   // DEPTH cycles of FLUSH
        do_txn(K_RD, 0, 1, 1);   // both lines invalid afterwards
        do_txn(K_RD, 31, 4, 2);

        // Random traffic over a few hot lines with two tags each
        for (int n = 0; n < 250; n++) begin
            r   = $urandom_range(0, 99);
            idx = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 5);
            tg  = $urandom_range(0, 1);
            d   = $urandom_range(1, 4);
            if (r < 50)      do_txn(K_RD, idx, tg, d);
            else if (r < 93) do_txn(K_WR, idx, tg, d);
            else             do_txn(K_FL, idx, tg, d);
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
        end
        check("sb_drain", exp_q.size(), 0);

`ifdef DCACHE_STATS_EN
        check("stats_hit_cnt",  int'(rd_hit_cnt),  m_hits);
        check("stats_miss_cnt", int'(rd_miss_cnt), m_misses);
`endif

        // Reset in the middle of a read miss
        mon_en  = 1'b0;
        rst_tag = m_valid[9] ? int'(m_tag[9] + 3'd1) : 1;
        @(posedge clk); #1;
        MemRead = 1'b1; index = 5'd9; tag = 3'(rst_tag);
        @(posedge clk); #1;           // now waiting in the miss state
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_stall",  int'(stall),  0);
        check("rst_mid_msread", int'(MsRead), 0);
        check("rst_mid_fill",   int'(fill),   0);
        check("rst_mid_hit",    int'(hit),    0);
        @(posedge clk); #1;
        rst = 1'b0; MemRead = 1'b0;
        model_reset();
        @(negedge clk);
        check("post_rst_outputs", int'({stall, fill, update, MsRead, MsWrite}), 0);
`ifdef DCACHE_STATS_EN
        check("post_rst_hit_cnt",  int'(rd_hit_cnt),  0);
        check("post_rst_miss_cnt", int'(rd_miss_cnt), 0);
`endif
        mon_en = 1'b1;
        do_txn(K_RD, 9, rst_tag, 2);  // line abandoned mid-miss must be invalid
        do_txn(K_RD, 3, 6, 1);        // reset cleared every line
        check("sb_drain_final", exp_q.size(), 0);

        finish_now();
    end

endmodule : tb_dcache_ctrl_dm
`default_nettype wire
